// File: rtl/imm_pkg.sv
// Shared immediate-format constants used by decode, the ALU source mux and the
// immediate extension pipeline.
package imm_pkg;

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate formatter: sign / zero / upper / sign-extend-and-shift,
// with an overflow flag for significant bits lost by the shift.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data,
  output logic             ovf
);

  logic signed [IN_W-1:0] imm_s;
  logic [OUT_W-1:0]       sext;
  logic [OUT_W-1:0]       zext;
  logic [OUT_W-1:0]       upper;
  logic [OUT_W-1:0]       shifted;
  logic                   lost;

  assign imm_s   = imm;
  assign sext    = OUT_W'(imm_s);
  assign zext    = OUT_W'(imm);
  assign shifted = sext << SHAMT;

  always_comb begin
    upper = '0;
    upper[OUT_W-1 -: IN_W] = imm;
  end

  // Bits pushed off the top must all match the surviving MSB, else the value changed.
  always_comb begin
    lost = 1'b0;
    for (int i = 0; i < SHAMT; i++) begin
      if (sext[OUT_W-1-i] != shifted[OUT_W-1]) lost = 1'b1;
    end
  end

  always_comb begin
    data = sext;
    ovf  = 1'b0;
    case (mode)
      MODE_SIGN:  data = sext;
      MODE_ZERO:  data = zext;
      MODE_UPPER: data = upper;
      MODE_SHIFT: begin
        data = shifted;
        ovf  = lost;
      end
      default:    data = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: valid/ready handshake in front of a 2-entry
// skid buffer (output register + skid register) for full-rate backpressure.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing buffered, ready to accept
// ST_ONE   | output register valid, still ready to accept
// ST_TWO   | output and skid registers full, not ready
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  occ_e           state, state_nx;
  logic [OUT_W:0] out_q, out_nx;
  logic [OUT_W:0] skid_q, skid_nx;
  logic [OUT_W:0] fmt;
  logic [OUT_W-1:0] fmt_data;
  logic           fmt_ovf;
  logic           accept, xfer;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHAMT (SHAMT)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (fmt_data),
    .ovf  (fmt_ovf)
  );

  assign fmt       = {fmt_ovf, fmt_data};
  assign in_ready  = rst_n && (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_data  = out_q[OUT_W-1:0];
  assign out_ovf   = out_q[OUT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      out_q  <= out_nx;
      skid_q <= skid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    out_nx   = out_q;
    skid_nx  = skid_q;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          out_nx   = fmt;
          state_nx = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          out_nx = fmt;
        end else if (accept) begin
          skid_nx  = fmt;
          state_nx = ST_TWO;
        end else if (xfer) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          out_nx   = skid_q;
          state_nx = ST_ONE;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: table-driven format checks on a default
// and a narrow (OUT_W=16) instance, plus backpressure, streaming and reset cases.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [31:0] out_data;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2;
  logic [15:0] in_imm2;
  logic [1:0]  in_mode2;
  logic [15:0] out_data2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] rx_data[$];
  int          rx_cyc[$];

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [31:0] data;
    logic        ovf;
  } vec_t;

  vec_t tbl[10];
  vec_t tbl16[6];

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  imm_extend_pipe #(.IN_W(16), .OUT_W(16), .SHAMT(2)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2), .in_mode(in_mode2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ovf(out_ovf2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 2 time units after posedge, so the negedge sees a stable cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one item and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode);
    logic acc;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
  endtask

  initial begin
    tbl[0] = '{2'b00, 16'hFFC0, 32'hFFFFFFC0, 1'b0};
    tbl[1] = '{2'b01, 16'hFFC0, 32'h0000FFC0, 1'b0};
    tbl[2] = '{2'b00, 16'h07C0, 32'h000007C0, 1'b0};
    tbl[3] = '{2'b00, 16'h0000, 32'h00000000, 1'b0};
    tbl[4] = '{2'b10, 16'h07C0, 32'h07C00000, 1'b0};
    tbl[5] = '{2'b11, 16'h8000, 32'hFFFE0000, 1'b0};
    tbl[6] = '{2'b11, 16'h7FFF, 32'h0001FFFC, 1'b0};
    tbl[7] = '{2'b11, 16'h4000, 32'h00010000, 1'b0};
    tbl[8] = '{2'b01, 16'h8000, 32'h00008000, 1'b0};
    tbl[9] = '{2'b10, 16'hFFFF, 32'hFFFF0000, 1'b0};

    tbl16[0] = '{2'b11, 16'h4000, 32'h0000, 1'b1};
    tbl16[1] = '{2'b11, 16'hF000, 32'hC000, 1'b0};
    tbl16[2] = '{2'b11, 16'h2000, 32'h8000, 1'b1};
    tbl16[3] = '{2'b00, 16'h8001, 32'h8001, 1'b0};
    tbl16[4] = '{2'b10, 16'h1234, 32'h1234, 1'b0};
    tbl16[5] = '{2'b01, 16'hF000, 32'hF000, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;  in_imm = '0;  in_mode = '0;  out_ready = 1'b1;
    in_valid2 = 1'b0; in_imm2 = '0; in_mode2 = '0; out_ready2 = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    step();

    foreach (tbl[i]) begin
      send(tbl[i].imm, tbl[i].mode);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].data);
      chk($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(tbl[i].ovf));
    end
    repeat (2) step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    foreach (tbl16[i]) begin
      in_valid2 = 1'b1; in_imm2 = tbl16[i].imm; in_mode2 = tbl16[i].mode;
      @(negedge clk);
      chk($sformatf("n16_%0d_ready", i), 32'(in_ready2), 32'd1);
      step();
      in_valid2 = 1'b0;
      chk($sformatf("n16_%0d_valid", i), 32'(out_valid2), 32'd1);
      chk($sformatf("n16_%0d_data", i), 32'(out_data2), tbl16[i].data);
      chk($sformatf("n16_%0d_ovf", i), 32'(out_ovf2), 32'(tbl16[i].ovf));
    end
    repeat (2) step();

    // Backpressure: A and B fill both entries, C must wait.
    rx_data.delete(); rx_cyc.delete();
    out_ready = 1'b0;
    send(16'h0001, 2'b00);
    send(16'h0002, 2'b00);
    in_valid = 1'b1; in_imm = 16'h0003; in_mode = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold_data", out_data, 32'h00000001);
      step();
    end
    out_ready = 1'b1;
    send(16'h0003, 2'b00);
    repeat (4) step();
    chk("bp_count", 32'(rx_data.size()), 32'd3);
    for (int k = 0; k < 3 && k < rx_data.size(); k++)
      chk($sformatf("bp_order%0d", k), rx_data[k], 32'(k + 1));

    // Streaming: back-to-back ZERO-mode items must leave on consecutive cycles.
    rx_data.delete(); rx_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      send(16'(k * 16'h1111), 2'b01);
      if (k == 0) chk("stream_latency", 32'(out_valid), 32'd1);
    end
    repeat (3) step();
    chk("stream_count", 32'(rx_data.size()), 32'd8);
    for (int k = 0; k < 8 && k < rx_data.size(); k++) begin
      chk($sformatf("stream_data%0d", k), rx_data[k], 32'(k * 32'h1111));
      if (k > 0) chk($sformatf("stream_gap%0d", k), 32'(rx_cyc[k] - rx_cyc[k-1]), 32'd1);
    end

    // Reset while both entries are full: nothing stale may come out afterwards.
    out_ready = 1'b0;
    send(16'h00AA, 2'b00);
    send(16'h00BB, 2'b00);
    rx_data.delete(); rx_cyc.delete();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready_rise", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) step();
    chk("rst2_no_stale", 32'(rx_data.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
